// File: rtl/time_entry_pkg.sv
// Shared types and constants for the time_entry keypad front end.
package time_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        LOAD  = 2'd2,
        START = 2'd3
    } state_t;

    localparam logic [3:0] KEY_CLEAR_DEFAULT = 4'hA;
    localparam logic [3:0] KEY_START_DEFAULT = 4'hB;

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_tens;
        logic [3:0] sec_units;
    } bcd_time_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/time_entry_sec_normalizer.sv
// Combinational BCD normalizer: folds 60-99 entered seconds into the minute digit,
// clamping to 9:59 when the minute digit cannot carry.
module sec_normalizer (
    input  logic [3:0] entry_min,
    input  logic [3:0] entry_sec_tens,
    input  logic [3:0] entry_sec_units,
    output logic [3:0] norm_min,
    output logic [3:0] norm_sec_tens,
    output logic [3:0] norm_sec_units
);

    logic [6:0] seconds;

    assign seconds = ({3'b000, entry_sec_tens} * 7'd10) + {3'b000, entry_sec_units};

    // S >= 60 implies the tens digit is at least 6, so S-60 is just tens-6 in BCD.
    always_comb begin
        norm_min       = entry_min;
        norm_sec_tens  = entry_sec_tens;
        norm_sec_units = entry_sec_units;
        if (seconds >= 7'd60) begin
            if (entry_min < 4'd9) begin
                norm_min      = entry_min + 4'd1;
                norm_sec_tens = entry_sec_tens - 4'd6;
            end else begin
                norm_sec_tens  = 4'd5;
                norm_sec_units = 4'd9;
            end
        end
    end

endmodule

// File: rtl/time_entry.sv
// Keypad time entry: collects m:ss digits, then issues load and start to the countdown chain.
// Optional seconds normalization is enabled by defining TIME_ENTRY_NORMALIZE_EN.
module time_entry
    import time_entry_pkg::*;
#(
    parameter logic [3:0] KEY_CLEAR = KEY_CLEAR_DEFAULT,
    parameter logic [3:0] KEY_START = KEY_START_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       run,
    output logic [3:0] disp_min,
    output logic [3:0] disp_sec_tens,
    output logic [3:0] disp_sec_units,
    output logic [3:0] data_min,
    output logic [3:0] data_sec_tens,
    output logic [3:0] data_sec_units,
    output logic       loadn,
    output logic       start
);

    state_t    state_reg, state_next;
    bcd_time_t entry_reg, entry_next;
    bcd_time_t data_reg, data_next;
    bcd_time_t norm_value;
    logic      loadn_reg;
    logic      start_reg;

`ifdef TIME_ENTRY_NORMALIZE_EN
    sec_normalizer u_sec_normalizer (
        .entry_min      (entry_reg.min),
        .entry_sec_tens (entry_reg.sec_tens),
        .entry_sec_units(entry_reg.sec_units),
        .norm_min       (norm_value.min),
        .norm_sec_tens  (norm_value.sec_tens),
        .norm_sec_units (norm_value.sec_units)
    );
`else
    assign norm_value = entry_reg;
`endif

    // Strobes are registered off the state, landing one cycle after LOAD/START is entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            entry_reg <= '0;
            data_reg  <= '0;
            loadn_reg <= 1'b1;
            start_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            entry_reg <= entry_next;
            data_reg  <= data_next;
            loadn_reg <= (state_reg != LOAD);
            start_reg <= (state_reg == START);
        end
    end

    always_comb begin
        state_next = state_reg;
        entry_next = entry_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (key_valid) begin
                    if (key_code == KEY_CLEAR) begin
                        entry_next = '0;
                    end else if (!run && is_digit(key_code)) begin
                        entry_next = {entry_reg.sec_tens, entry_reg.sec_units, key_code};
                    end else if (!run && key_code == KEY_START && entry_reg != '0) begin
                        state_next = NORM;
                    end
                end
            end
            NORM: begin
                data_next  = norm_value;
                state_next = LOAD;
            end
            LOAD: begin
                state_next = START;
            end
            START: begin
                entry_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign disp_min       = entry_reg.min;
    assign disp_sec_tens  = entry_reg.sec_tens;
    assign disp_sec_units = entry_reg.sec_units;
    assign data_min       = data_reg.min;
    assign data_sec_tens  = data_reg.sec_tens;
    assign data_sec_units = data_reg.sec_units;
    assign loadn          = loadn_reg;
    assign start          = start_reg;

endmodule
